layer_compositor: RTL and testbench

- Parametrised, pipelined successor to the top-level graphics mixer.
- Merges floor, object, N player and HUD pixel layers into one 12-bit RGB stream using a fixed priority and a transparency key.
- Delays hsync/vsync/blank to stay aligned with the pixel pipeline, latches per-frame controls on the frame boundary, and blinks the HUD when time is low.
- Sits between the per-layer sprite generators and the VGA output registers.

---
 rtl/gfx_pkg.sv | 32 +++
 rtl/layer_select.sv | 70 +++++++
 rtl/layer_compositor.sv | 170 +++++++++++++++++
 tb/tb_layer_compositor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// -----------------------------------------------------------------------------
// gfx_pkg
// Types and constants shared by the layer compositor and its selection logic.
//   pixel_t      12-bit RGB pixel (4 bits per channel).
//   TRANSPARENT  colour key meaning "this layer has nothing here".
//   GS_*         game-state codes used by the compositor.
//   sync_t       hsync/vsync/blank bundle that travels down the pixel pipeline.
// -----------------------------------------------------------------------------
package gfx_pkg;

  typedef logic [11:0] pixel_t;

  localparam pixel_t TRANSPARENT = 12'hFFF;

  localparam logic [2:0] GS_WELCOME = 3'd0;
  localparam logic [2:0] GS_PLAY    = 3'd1;
  localparam logic [2:0] GS_END     = 3'd2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  // Idle level of the sync bundle: both syncs inactive (high), blanking on.
  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  function automatic logic is_opaque(input pixel_t p);
    return p != TRANSPARENT;
  endfunction

endpackage

// File: rtl/layer_select.sv
// -----------------------------------------------------------------------------
// layer_select
// Combinational priority mux that picks one pixel out of the layer stack.
//   blank         1 = blanking, output forced to black.
//   floor_pixel   bottom layer, always shown when nothing above is opaque.
//   object_pixel  static object layer.
//   player_pixel  player layers, index 0 has the highest priority.
//   hud_pixel     HUD/text layer, top-most.
//   np            highest player index in use (already clamped).
//   gs            game-state code.
//   hud_visible   0 while the HUD is in the "off" half of its blink.
//   pixel         selected pixel.
// -----------------------------------------------------------------------------
module layer_select
  import gfx_pkg::*;
#(
  parameter int     NUM_PLAYERS = 4,
  parameter pixel_t BG_COLOR    = 12'h000
) (
  input  logic                         blank,
  input  pixel_t                       floor_pixel,
  input  pixel_t                       object_pixel,
  input  pixel_t [NUM_PLAYERS-1:0]     player_pixel,
  input  pixel_t                       hud_pixel,
  input  logic   [1:0]                 np,
  input  logic   [2:0]                 gs,
  input  logic                         hud_visible,
  output pixel_t                       pixel
);

  logic   player_hit;
  pixel_t player_sel;
  logic   hud_hit;

  assign hud_hit = hud_visible && is_opaque(hud_pixel);

  // Walk from the lowest priority player upward so the last assignment is the
  // lowest-index opaque player. Players above np are skipped entirely.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    player_hit = 1'b0;
    player_sel = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (i <= int'(np) && is_opaque(player_pixel[i])) begin
        player_hit = 1'b1;
        player_sel = player_pixel[i];
      end
    end
  end

  always_comb begin
    pixel = floor_pixel;
    if (blank) begin
      pixel = '0;
    end else if (gs != GS_PLAY) begin
      pixel = hud_hit ? hud_pixel : BG_COLOR;
    end else if (hud_hit) begin
      pixel = hud_pixel;
    end else if (player_hit) begin
      pixel = player_sel;
    end else if (is_opaque(object_pixel)) begin
      pixel = object_pixel;
    end else begin
      // The floor is passed through even when it equals the colour key.
      pixel = floor_pixel;
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
// Two-stage pixel pipeline that merges floor, object, player and HUD layers
// into one 12-bit RGB stream, keeping hsync/vsync/blank aligned with it.
// Per-frame controls are captured on the vsync falling edge so a frame is
// always composited with one consistent set of controls. When time is low the
// HUD blinks with a half-period of FLASH_FRAMES frames.
//   clock, reset       pixel clock, asynchronous active-high reset.
//   num_players        active players minus one (clamped to NUM_PLAYERS-1).
//   game_state         game-state code.
//   time_low           enables the HUD blink.
//   *_pixel            layer inputs.
//   hsync/vsync/blank  raster timing inputs.
//   *_out              timing and composited pixel, 2 cycles after the inputs.
//   frame_count        vsync falling edges since reset, wrapping.
// -----------------------------------------------------------------------------
module layer_compositor
  import gfx_pkg::*;
#(
  parameter int     NUM_PLAYERS  = 4,
  parameter int     FLASH_FRAMES = 16,
  parameter pixel_t BG_COLOR     = 12'h000,
  parameter int     FRAME_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic   [1:0]             num_players,
  input  logic   [2:0]             game_state,
  input  logic                     time_low,
  input  pixel_t                   floor_pixel,
  input  pixel_t                   object_pixel,
  input  pixel_t [NUM_PLAYERS-1:0] player_pixel,
  input  pixel_t                   hud_pixel,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     blank,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     blank_out,
  output pixel_t                   pixel_out,
  output logic   [FRAME_W-1:0]     frame_count
);

  localparam logic [1:0]      NP_MAX  = 2'(NUM_PLAYERS - 1);
  localparam int              FC_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Frame boundary detection and per-frame shadow controls
  // ---------------------------------------------------------------------------
  logic            vsync_d;
  logic            boundary;
  logic [1:0]      np_next;
  logic [1:0]      np_q;
  logic [2:0]      gs_q;
  logic            tl_q;
  logic [FC_W-1:0] flash_cnt;
  logic            flash_on;
  logic            hud_visible;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_d <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      vsync_d <= vsync;
    end
  end

  assign boundary = !vsync && vsync_d;
  assign np_next  = (num_players > NP_MAX) ? NP_MAX : num_players;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      np_q        <= '0;
      gs_q        <= GS_WELCOME;
      tl_q        <= 1'b0;
      frame_count <= '0;
    end else if (boundary) begin
      np_q        <= np_next;
      gs_q        <= game_state;
      tl_q        <= time_low;
      frame_count <= frame_count + FRAME_W'(1);
    end
  end

  // Blink timer advances once per frame, and restarts in the "on" phase
  // whenever time_low is dropped so the HUD reappears immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flash_cnt <= '0;
      flash_on  <= 1'b1;
    end else if (boundary) begin
      if (!time_low) begin
        flash_cnt <= '0;
        flash_on  <= 1'b1;
      end else if (flash_cnt == FC_LAST) begin
        flash_cnt <= '0;
        flash_on  <= ~flash_on;
      end else begin
        flash_cnt <= flash_cnt + FC_W'(1);
      end
    end
  end

  assign hud_visible = !tl_q || flash_on;

  // ---------------------------------------------------------------------------
  // Stage 1: register all layer pixels and the timing bundle
  // ---------------------------------------------------------------------------
  pixel_t                   floor_q;
  pixel_t                   object_q;
  pixel_t [NUM_PLAYERS-1:0] player_q;
  pixel_t                   hud_q;
  sync_t                    sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the pipeline datapath is reset too, so a mid-line reset drives
      // clean idle timing and black pixels until valid data refills it.
      floor_q  <= '0;
      object_q <= '0;
      player_q <= '0;
      hud_q    <= '0;
      sync_q   <= SYNC_IDLE;
    end else begin
      floor_q  <= floor_pixel;
      object_q <= object_pixel;
      player_q <= player_pixel;
      hud_q    <= hud_pixel;
      sync_q   <= '{hsync: hsync, vsync: vsync, blank: blank};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: layer selection and output registers
  // ---------------------------------------------------------------------------
  pixel_t sel_pixel;

  layer_select #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .BG_COLOR    (BG_COLOR)
  ) u_layer_select (
    .blank        (sync_q.blank),
    .floor_pixel  (floor_q),
    .object_pixel (object_q),
    .player_pixel (player_q),
    .hud_pixel    (hud_q),
    .np           (np_q),
    .gs           (gs_q),
    .hud_visible  (hud_visible),
    .pixel        (sel_pixel)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_out <= SYNC_IDLE.hsync;
      vsync_out <= SYNC_IDLE.vsync;
      blank_out <= SYNC_IDLE.blank;
      pixel_out <= '0;
    end else begin
      hsync_out <= sync_q.hsync;
      vsync_out <= sync_q.vsync;
      blank_out <= sync_q.blank;
      pixel_out <= sel_pixel;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
// Directed bench for layer_compositor. Two instances share all stimulus:
//   dut  : NUM_PLAYERS=4, FLASH_FRAMES=2, BG_COLOR=12'h123, FRAME_W=16
//   dut2 : NUM_PLAYERS=2, FLASH_FRAMES=16, BG_COLOR=12'h000, FRAME_W=8
// dut2 covers player-count clamping and frame counter wrap-around.
// -----------------------------------------------------------------------------
module tb_layer_compositor;
  import gfx_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   num_players;
  logic [2:0]   game_state;
  logic         time_low;
  pixel_t       floor_pixel;
  pixel_t       object_pixel;
  pixel_t [3:0] player_pixel;
  pixel_t       hud_pixel;
  logic         hsync, vsync, blank;

  logic         hsync_out, vsync_out, blank_out;
  pixel_t       pixel_out;
  logic [15:0]  frame_count;

  logic         hsync_out2, vsync_out2, blank_out2;
  pixel_t       pixel_out2;
  logic [7:0]   frame_count2;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  always #5 clock = ~clock;

  layer_compositor #(
    .NUM_PLAYERS (4),
    .FLASH_FRAMES(2),
    .BG_COLOR    (12'h123),
    .FRAME_W     (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .num_players  (num_players),
    .game_state   (game_state),
    .time_low     (time_low),
    .floor_pixel  (floor_pixel),
    .object_pixel (object_pixel),
    .player_pixel (player_pixel),
    .hud_pixel    (hud_pixel),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank        (blank),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .blank_out    (blank_out),
    .pixel_out    (pixel_out),
    .frame_count  (frame_count)
  );

  layer_compositor #(
    .NUM_PLAYERS (2),
    .FLASH_FRAMES(16),
    .BG_COLOR    (12'h000),
    .FRAME_W     (8)
  ) dut2 (
    .clock        (clock),
    .reset        (reset),
    .num_players  (num_players),
    .game_state   (game_state),
    .time_low     (time_low),
    .floor_pixel  (floor_pixel),
    .object_pixel (object_pixel),
    .player_pixel (player_pixel[1:0]),
    .hud_pixel    (hud_pixel),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank        (blank),
    .hsync_out    (hsync_out2),
    .vsync_out    (vsync_out2),
    .blank_out    (blank_out2),
    .pixel_out    (pixel_out2),
    .frame_count  (frame_count2)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick2();
    tick();
    tick();
  endtask

  // One vsync falling edge: vsync low for one cycle, then back high.
  task automatic frame_edge();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    frames++;
  endtask

  task automatic set_layers(input pixel_t p0, input pixel_t p1, input pixel_t p2,
                            input pixel_t p3, input pixel_t obj, input pixel_t flr,
                            input pixel_t hud);
    player_pixel[0] = p0;
    player_pixel[1] = p1;
    player_pixel[2] = p2;
    player_pixel[3] = p3;
    object_pixel    = obj;
    floor_pixel     = flr;
    hud_pixel       = hud;
  endtask

  // HUD blink with FLASH_FRAMES=2, starting from cnt=0/on=1, time_low=1.
  pixel_t flash_exp [7] = '{12'hF0F, 12'h888, 12'h888, 12'hF0F, 12'hF0F, 12'h888, 12'h888};

  initial begin
    reset       = 1'b1;
    num_players = 2'd0;
    game_state  = GS_WELCOME;
    time_low    = 1'b0;
    hsync       = 1'b1;
    vsync       = 1'b1;
    blank       = 1'b1;
    set_layers(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);

    // Reset state
    tick2();
    check("rst_hsync", 32'(hsync_out), 32'h1);
    check("rst_vsync", 32'(vsync_out), 32'h1);
    check("rst_blank", 32'(blank_out), 32'h1);
    check("rst_pixel", 32'(pixel_out), 32'h000);
    check("rst_frame", 32'(frame_count), 32'h0);
    reset = 1'b0;
    tick2();

    // Priority in play state, exact 2-cycle latency and sync alignment
    game_state  = GS_PLAY;
    num_players = 2'd3;
    frame_edge();
    check("vsync_delay2", 32'(vsync_out), 32'h0);
    set_layers(12'hFFF, 12'h0F0, 12'hF00, 12'h00F, 12'h00F, 12'h888, 12'hFFF);
    blank = 1'b0;
    hsync = 1'b0;
    tick();
    check("lat_not_1_blank", 32'(blank_out), 32'h1);
    blank = 1'b1;
    hsync = 1'b1;
    tick();
    check("p1_pixel",  32'(pixel_out),  32'h0F0);
    check("p1_hsync",  32'(hsync_out),  32'h0);
    check("p1_blank",  32'(blank_out),  32'h0);
    check("p1_vsync",  32'(vsync_out),  32'h1);
    check("clamp_p1",  32'(pixel_out2), 32'h0F0);
    tick();
    check("blank_pixel", 32'(pixel_out), 32'h000);
    check("blank_hsync", 32'(hsync_out), 32'h1);
    check("blank_flag",  32'(blank_out), 32'h1);

    // Player count limits and mid-frame control changes
    num_players = 2'd0;
    frame_edge();
    set_layers(12'hFFF, 12'hF00, 12'hFFF, 12'hFFF, 12'h00F, 12'h888, 12'hFFF);
    blank = 1'b0;
    tick2();
    check("np0_obj",  32'(pixel_out),  32'h00F);
    check("np0_obj2", 32'(pixel_out2), 32'h00F);
    num_players = 2'd1;
    tick2();
    check("np_midframe", 32'(pixel_out), 32'h00F);
    frame_edge();
    tick2();
    check("np1_player1", 32'(pixel_out), 32'hF00);

    // Floor pass-through, blanking, non-play background
    num_players = 2'd3;
    frame_edge();
    set_layers(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    tick2();
    check("floor_fff", 32'(pixel_out), 32'hFFF);
    blank = 1'b1;
    tick2();
    check("floor_blank", 32'(pixel_out), 32'h000);
    blank      = 1'b0;
    game_state = GS_END;
    frame_edge();
    tick2();
    check("end_bg",  32'(pixel_out),  32'h123);
    check("end_bg2", 32'(pixel_out2), 32'h000);
    hud_pixel = 12'hF0F;
    tick2();
    check("end_hud", 32'(pixel_out), 32'hF0F);

    // HUD blink
    game_state = GS_PLAY;
    time_low   = 1'b1;
    set_layers(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h888, 12'hF0F);
    for (int f = 0; f < 7; f++) begin
      frame_edge();
      tick2();
      check($sformatf("flash_f%0d", f + 1), 32'(pixel_out), 32'(flash_exp[f]));
      check($sformatf("flash2_f%0d", f + 1), 32'(pixel_out2), 32'hF0F);
    end
    time_low = 1'b0;
    frame_edge();
    tick2();
    check("flash_off_hud", 32'(pixel_out), 32'hF0F);

    // Frame counter and wrap-around (dut2 wraps at 256)
    repeat (300) frame_edge();
    check("frame_cnt16", 32'(frame_count),  32'(16'(frames)));
    check("frame_cnt8",  32'(frame_count2), 32'(8'(frames)));

    // Reset in the middle of a line
    hsync = 1'b0;
    tick2();
    check("pre_rst_pixel", 32'(pixel_out), 32'hF0F);
    reset = 1'b1;
    #1;
    check("mid_rst_hsync", 32'(hsync_out),    32'h1);
    check("mid_rst_vsync", 32'(vsync_out),    32'h1);
    check("mid_rst_blank", 32'(blank_out),    32'h1);
    check("mid_rst_pixel", 32'(pixel_out),    32'h000);
    check("mid_rst_frame", 32'(frame_count),  32'h0);
    check("mid_rst_frame2", 32'(frame_count2), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("refill_1_blank", 32'(blank_out), 32'h1);
    tick();
    check("refill_2_pixel", 32'(pixel_out), 32'hF0F);
    check("refill_2_hsync", 32'(hsync_out), 32'h0);
    check("refill_2_blank", 32'(blank_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
